lp_cutoff_scheduler: RTL and testbench
======================================

// Module: lp_cutoff_scheduler
// PURPOSE
//   Owns the CUTOFF_EXP word that drives the LP_FIRST_PART bitstream filter.
//   Arbitrates cutoff-change requests from N_REQ sources (envelope, LFO, host) round-robin.
//   Slews the granted change toward its target at a programmable rate, one step per tick,
//   so the 1-bit integrator/SDM loop never sees zipper-step discontinuities.
// PARAMETERS
//   WIDTH      15      cutoff word width; matches the filter CUTOFF_EXP input
//   N_REQ      3       number of requesters
//   STEP_W     8       width of per-request slew step
//   TICK_DIV   1024    clk cycles per slew tick; legal range >= 2
//   RST_CUTOFF 4096    CUTOFF_EXP value after reset
// PORTS
//   clk         in   1              system clock
//   rst         in   1              synchronous, active-high reset
//   req         in   N_REQ          level request per source; hold until granted
//   req_target  in   N_REQ*WIDTH    packed target cutoff, source i at [i*WIDTH +: WIDTH]
//   req_step    in   N_REQ*STEP_W   packed slew step per tick; 0 = jump immediately
//   grant       out  N_REQ          one-hot, 1-cycle pulse when a request is accepted
//   busy        out  1              high from grant cycle until ramp completes
//   done        out  1              1-cycle pulse when CUTOFF_EXP reaches target
//   CUTOFF_EXP  out  WIDTH          cutoff word to the filter, registered
// BEHAVIOUR
//   Reset: state IDLE, CUTOFF_EXP=RST_CUTOFF, grant=0, busy=0, done=0,
//     RR pointer=0, tick counter=0. Reset mid-ramp abandons the ramp; no done pulse.
//   FSM states:
//     IDLE  -> GRANT when any req=1.
//     GRANT -> RAMP. Latch target/step of the winner, pulse grant[w], set busy.
//     RAMP  -> DONE when CUTOFF_EXP==target.
//     DONE  -> IDLE. Pulse done, clear busy.
//   Arbitration in IDLE: search starts at RR pointer, wraps modulo N_REQ.
//     Pointer <= winner+1 (mod N_REQ) on grant.
//   No preemption: requests arriving during GRANT/RAMP/DONE wait. They are considered
//     in the first IDLE cycle after DONE, so each change costs at least 3 idle-free cycles.
//   Tick: free-running counter 0..TICK_DIV-1, never reset by the FSM.
//     A tick is the cycle the counter equals TICK_DIV-1.
//   RAMP update, only on tick cycles:
//     Magnitude |target-CUTOFF_EXP| is computed unsigned in WIDTH+1 bits.
//     If step==0 or magnitude<=step: CUTOFF_EXP<=target, else move by step toward target.
//     Never overshoots; never wraps through 0 or 2^WIDTH-1.
//   Target already equal to CUTOFF_EXP: RAMP exits on its first cycle without a tick; done still pulses.
//   step==0: jump happens on the first tick in RAMP, not immediately in GRANT.
//   Latency: req high in IDLE -> grant on next edge; done 1 cycle after the final step.
//   req_target/req_step are sampled only in GRANT; later changes do not affect the active ramp.
//   A requester must drop req after seeing grant, else it is re-arbitrated on the next IDLE.
//   CUTOFF_EXP changes only in RAMP tick cycles or on reset.
// STRUCTURE
//   Shared package lp_ctrl_pkg:
//     FSM state enum (IDLE, GRANT, RAMP, DONE).
//     Default WIDTH/STEP_W constants, RST_CUTOFF.
//   Sub-module rr_arbiter #(N):
//     Combinational one-hot winner from req and pointer, plus registered pointer update on grant_en.
//     Reusable for the resonance/drive schedulers.
//   Top level: FSM, tick counter, target/step latch, slew datapath.
// TESTING (bench uses TICK_DIV=4)
//   1. Reset: assert rst 3 cycles.
//      -> CUTOFF_EXP=4096, busy=0, grant=0, done=0; rst mid-ramp returns same values next edge.
//   2. Single ramp: req[0] target=4106 step=4.
//      -> grant=001 once; CUTOFF_EXP 4100, 4104, 4106 on successive ticks; done pulses once; busy drops.
//   3. Downward/jump: target=0 step=0 from 4096.
//      -> CUTOFF_EXP=0 at the first tick; no underflow; done pulses.
//   4. Round-robin: req=111 held, each target=current.
//      -> grants 001, 010, 100, 001 in order; pointer wraps.
//   5. No preemption: req[1] raised mid-ramp of req[0] (target 5000 step 1).
//      -> grant[1] only after done for req[0]; req_target[1] changed during the wait is used as sampled in GRANT.
//   6. Clamp: CUTOFF_EXP=32760, target=32767, step=255.
//      -> CUTOFF_EXP=32767 exactly, no wrap.

Source files
------------

// File: rtl/lp_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : lp_ctrl_pkg
// Brief  : Shared constants and FSM encoding for the LP filter control schedulers.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package lp_ctrl_pkg;

  localparam int C_WIDTH      = 15;
  localparam int C_STEP_W     = 8;
  localparam int C_RST_CUTOFF = 4096;

  typedef logic [1:0] state_t;

  localparam state_t C_IDLE  = 2'd0;
  localparam state_t C_GRANT = 2'd1;
  localparam state_t C_RAMP  = 2'd2;
  localparam state_t C_DONE  = 2'd3;

  // A single requester still needs a 1-bit pointer to keep ranges legal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module : rr_arbiter
// Brief  : Round-robin one-hot arbiter; pointer advances past the winner on grant_en_i.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import lp_ctrl_pkg::*;
#(
  parameter int N     = 3,
  parameter int PTR_W = ptr_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             grant_en_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] winner_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] cand;
  logic             found;

  // Search begins at the pointer and wraps, so the first hit is the fairest winner.
  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    cand     = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % N);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        grant_o[cand]  = 1'b1;
        winner_o       = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (grant_en_i) begin
      ptr_q <= (winner_o == PTR_W'(N - 1)) ? '0 : winner_o + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lp_cutoff_scheduler.sv
//------------------------------------------------------------------------------
// Module : lp_cutoff_scheduler
// Brief  : Arbitrates cutoff-change requests and slews CUTOFF_EXP toward the target.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lp_cutoff_scheduler
  import lp_ctrl_pkg::*;
#(
  parameter int WIDTH      = C_WIDTH,
  parameter int N_REQ      = 3,
  parameter int STEP_W     = C_STEP_W,
  parameter int TICK_DIV   = 1024,
  parameter int RST_CUTOFF = C_RST_CUTOFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WIDTH-1:0]  req_target,
  input  logic [N_REQ*STEP_W-1:0] req_step,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        CUTOFF_EXP
);

  localparam int               PTR_W     = ptr_width(N_REQ);
  localparam int               CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                tick;
  logic                arb_en;
  logic [N_REQ-1:0]    arb_onehot;
  logic [PTR_W-1:0]    arb_idx, win_q;
  logic [N_REQ-1:0]    grant_q;
  logic                busy_q, done_q;
  logic [WIDTH-1:0]    target_q, cutoff_q, cutoff_d, sel_target, slew_val;
  logic [STEP_W-1:0]   step_q, sel_step;
  logic [WIDTH:0]      mag, step_ext;
  logic                up;

  assign tick   = (cnt_q == TICK_LAST);
  assign arb_en = (state_q == C_IDLE) && (|req);

  // Free-running tick divider, independent of the FSM.
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .grant_en_i (arb_en),
    .grant_o    (arb_onehot),
    .winner_o   (arb_idx)
  );

  always_comb begin
    sel_target = '0;
    sel_step   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_q == PTR_W'(i)) begin
        sel_target = req_target[i*WIDTH +: WIDTH];
        sel_step   = req_step[i*STEP_W +: STEP_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (|req) state_d = C_GRANT;
      C_GRANT: state_d = C_RAMP;
      C_RAMP:  if (cutoff_q == target_q) state_d = C_DONE;
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // Distance is taken one bit wider so the step comparison can never wrap.
  always_comb begin
    up       = (target_q > cutoff_q);
    mag      = up ? ({1'b0, target_q} - {1'b0, cutoff_q})
                  : ({1'b0, cutoff_q} - {1'b0, target_q});
    step_ext = (WIDTH+1)'(step_q);
    if ((step_q == '0) || (mag <= step_ext)) begin
      slew_val = target_q;
    end else if (up) begin
      slew_val = cutoff_q + WIDTH'(step_q);
    end else begin
      slew_val = cutoff_q - WIDTH'(step_q);
    end
    cutoff_d = cutoff_q;
    if ((state_q == C_RAMP) && tick) begin
      cutoff_d = slew_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= C_IDLE;
      cutoff_q <= WIDTH'(RST_CUTOFF);
      grant_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      win_q    <= '0;
      target_q <= '0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      cutoff_q <= cutoff_d;
      grant_q  <= arb_en ? arb_onehot : '0;
      busy_q   <= (state_d == C_GRANT) || (state_d == C_RAMP);
      done_q   <= (state_d == C_DONE);
      if (arb_en) begin
        win_q <= arb_idx;
      end
      if (state_q == C_GRANT) begin
        target_q <= sel_target;
        step_q   <= sel_step;
      end
    end
  end

  assign grant      = grant_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign CUTOFF_EXP = cutoff_q;

endmodule

`default_nettype wire

// File: tb/tb_lp_cutoff_scheduler.sv
//------------------------------------------------------------------------------
// Module : tb_lp_cutoff_scheduler
// Brief  : Self-checking bench for lp_cutoff_scheduler with a transaction-level model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lp_cutoff_scheduler;

  localparam int W  = 15;
  localparam int N  = 3;
  localparam int SW = 8;
  localparam int TD = 4;
  localparam int RC = 4096;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*W-1:0]  req_target;
  logic [N*SW-1:0] req_step;
  logic [N-1:0]    grant;
  logic            busy, done;
  logic [W-1:0]    CUTOFF_EXP;

  lp_cutoff_scheduler #(
    .WIDTH      (W),
    .N_REQ      (N),
    .STEP_W     (SW),
    .TICK_DIV   (TD),
    .RST_CUTOFF (RC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_target (req_target),
    .req_step   (req_step),
    .grant      (grant),
    .busy       (busy),
    .done       (done),
    .CUTOFF_EXP (CUTOFF_EXP)
  );

  always #5 clk = ~clk;

  typedef struct {
    int src;
    int tgt;
    int stp;
    int exp_fin;
    int exp_n;
  } vec_t;

  vec_t tbl[9];
  int   total = 0, bad = 0, cyc = 0;
  int   cm, ptr_m, idle_from, raise_cyc, pend;
  bit   scramble, hook_on;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  // Cycle index restarts at 0 in the first cycle after an edge that saw rst high.
  task automatic step();
    bit r;
    r = rst;
    @(posedge clk);
    #1;
    cyc = r ? 0 : cyc + 1;
  endtask

  task automatic set_src(input int s, input int t, input int st);
    req_target[s*W +: W]  = W'(t);
    req_step[s*SW +: SW]  = SW'(st);
  endtask

  function automatic int slew(input int cur, input int tgt, input int st);
    int mag;
    mag = (tgt > cur) ? tgt - cur : cur - tgt;
    if (st == 0 || mag <= st) return tgt;
    return (tgt > cur) ? cur + st : cur - st;
  endfunction

  function automatic int rr_pick(input int p, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (((p >> ((ptr + k) % N)) & 1) != 0) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    step();
    chk("rst_cutoff", int'(CUTOFF_EXP), RC);
    chk("rst_flags", int'({grant, busy, done}), 0);
    step();
    step();
    rst = 1'b0;
    cm = RC; ptr_m = 0; pend = 0; idle_from = 0; raise_cyc = 0;
  endtask

  // One complete grant/ramp/done transaction, checked cycle by cycle.
  task automatic serve(input bit hold, output int nchg, output int fin);
    int w, g, gexp, tgt, st, nv, dc, ex, t, prev;
    int q[$];
    nchg = 0;
    fin  = -1;
    w    = rr_pick(pend, ptr_m);
    gexp = ((raise_cyc > idle_from) ? raise_cyc : idle_from) + 1;
    t    = 0;
    while (t < 30) begin
      step();
      t++;
      if (grant != '0) break;
      chk("idle_cutoff", int'(CUTOFF_EXP), cm);
      chk("idle_flags", int'({busy, done}), 0);
    end
    if (grant == '0) begin
      chk("grant_timeout", 0, 1);
      return;
    end
    g = cyc;
    chk("grant_cycle", g, gexp);
    chk("grant_onehot", int'(grant), 1 << w);
    chk("grant_flags", int'({busy, done}), 2);
    tgt   = int'(req_target[w*W +: W]);
    st    = int'(req_step[w*SW +: SW]);
    ptr_m = (w + 1) % N;
    if (!hold) begin
      req  = req & ~N'(1 << w);
      pend = pend & ~(1 << w);
    end
    ex = cm;
    while (ex != tgt) begin
      ex = slew(ex, tgt, st);
      q.push_back(ex);
    end
    nv = g + 1;
    while (nv % TD != TD - 1) nv++;
    nv++;
    dc   = (q.size() == 0) ? g + 2 : nv + TD * (q.size() - 1) + 1;
    ex   = cm;
    prev = int'(CUTOFF_EXP);
    while (cyc < dc) begin
      step();
      if (cyc == g + 1 && scramble) set_src(w, $urandom_range(0, 32767), $urandom_range(0, 255));
      if (hook_on && cyc == g + 10) begin
        req = req | N'(2);
        pend = pend | 2;
        raise_cyc = cyc;
        set_src(1, 4500, 50);
      end
      if (hook_on && cyc == g + 500) set_src(1, 4700, 50);
      if (q.size() != 0 && cyc == nv) begin
        ex = q.pop_front();
        nv += TD;
      end
      if (int'(CUTOFF_EXP) != prev) nchg++;
      prev = int'(CUTOFF_EXP);
      chk("ramp_cutoff", int'(CUTOFF_EXP), ex);
      chk("ramp_grant", int'(grant), 0);
      chk("ramp_busy", int'(busy), (cyc < dc) ? 1 : 0);
      chk("ramp_done", int'(done), (cyc == dc) ? 1 : 0);
    end
    fin       = int'(CUTOFF_EXP);
    cm        = tgt;
    idle_from = dc + 1;
  endtask

  initial begin
    int n, f, m, t, st;
    req = '0; req_target = '0; req_step = '0; rst = 1'b1;
    scramble = 1'b1; hook_on = 1'b0;
    cm = RC; ptr_m = 0; pend = 0; idle_from = 0; raise_cyc = 0;

    tbl[0] = '{0, 4106,  4,   4106,  3};
    tbl[1] = '{1, 4096,  5,   4096,  2};
    tbl[2] = '{2, 0,     0,   0,     1};
    tbl[3] = '{0, 0,     3,   0,     0};
    tbl[4] = '{1, 10,    255, 10,    1};
    tbl[5] = '{2, 32760, 0,   32760, 1};
    tbl[6] = '{0, 32767, 255, 32767, 1};
    tbl[7] = '{1, 32767, 1,   32767, 0};
    tbl[8] = '{2, 32765, 1,   32765, 2};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_src(tbl[i].src, tbl[i].tgt, tbl[i].stp);
      req  = req | N'(1 << tbl[i].src);
      pend = pend | (1 << tbl[i].src);
      raise_cyc = cyc;
      serve(1'b0, n, f);
      chk("tbl_final", f, tbl[i].exp_fin);
      chk("tbl_steps", n, tbl[i].exp_n);
    end

    // Reset in the middle of a slow ramp.
    do_reset();
    set_src(0, 4200, 1);
    req = N'(1);
    for (int i = 0; i < 10 && grant == '0; i++) step();
    chk("mr_grant", int'(grant), 1);
    req = '0;
    repeat (12) step();
    chk("mr_moving", int'(CUTOFF_EXP > W'(RC)), 1);
    rst = 1'b1;
    step();
    chk("mr_cutoff", int'(CUTOFF_EXP), RC);
    chk("mr_flags", int'({grant, busy, done}), 0);
    step();
    rst = 1'b0;
    cm = RC; ptr_m = 0; pend = 0; idle_from = 0; raise_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mr_after", int'({CUTOFF_EXP, busy, done}), RC << 2);
    end

    // Round-robin with all requests held and no-op targets.
    do_reset();
    scramble = 1'b0;
    for (int s = 0; s < N; s++) set_src(s, RC, $urandom_range(0, 255));
    req = N'(7); pend = 7; raise_cyc = cyc;
    for (int i = 0; i < 4; i++) begin
      serve(1'b1, n, f);
      chk("rr_final", f, RC);
    end
    req = '0; pend = 0;
    scramble = 1'b1;

    // No preemption: req[1] arrives mid-ramp and its target changes while waiting.
    do_reset();
    set_src(0, 5000, 1);
    req = N'(1); pend = 1; raise_cyc = cyc;
    hook_on = 1'b1;
    serve(1'b0, n, f);
    hook_on = 1'b0;
    chk("np_first", f, 5000);
    serve(1'b0, n, f);
    chk("np_second", f, 4700);
    chk("np_second_steps", n, 6);

    // Randomized contention against the model.
    for (int it = 0; it < 12; it++) begin
      m = $urandom_range(1, 7);
      for (int s = 0; s < N; s++) begin
        if (((m >> s) & 1) != 0) begin
          case ($urandom_range(0, 3))
            0:       t = 0;
            1:       t = 32767;
            2:       t = $urandom_range(0, 32767);
            default: t = cm + $urandom_range(0, 40) - 20;
          endcase
          if (t < 0) t = 0;
          if (t > 32767) t = 32767;
          st = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(100, 255);
          set_src(s, t, st);
        end
      end
      req = req | N'(m); pend = pend | m; raise_cyc = cyc;
      while (pend != 0) serve(1'b0, n, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
